rr_encoder_arbiter: RTL
=======================

Name: rr_encoder_arbiter

Overview:
- Round-robin arbiter that shares one 4-to-2 encoded resource between four requesters.
- Outputs a one-hot grant and the 2-bit encoded index of the winner, so the downstream encoded datapath consumes grant_idx directly.
- Enforces fair rotation and a bounded hold time so no requester can monopolise the resource.

Parameters:
- MAX_HOLD, 8, maximum cycles a grant may be held while another requester is waiting (legal range 2..2^HOLD_W).
- HOLD_W, 4, width of the hold counter; must satisfy MAX_HOLD <= 2^HOLD_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  level requests; bit i is requester i; the requester holds it until served
- done  input  1  one-cycle release pulse from the current owner; ignored while grant_valid=0
- grant  output  4  registered one-hot grant; 0 when idle
- grant_idx  output  2  registered encoded index of the owner; holds its last value while idle
- grant_valid  output  1  high while any grant bit is set
- preempt  output  1  one-cycle pulse when a grant is revoked by hold timeout

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n=0) acts immediately and does not wait for a clock edge:
  - grant=0, grant_idx=0, grant_valid=0, preempt=0.
  - Priority pointer ptr=0, hold_cnt=0, state=IDLE.
- All outputs are registered. No combinational path from req or done to any output.
- State IDLE:
  - If req!=0, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set bit wins.
  - Next edge: grant=onehot(win), grant_idx=win, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency: the first edge that samples req high asserts grant (1 cycle).
  - If req==0, stay in IDLE with outputs unchanged.
- State GRANT (owner o=grant_idx). Release occurs at the next edge if any of the following holds:
  - (a) done=1
  - (b) req[o]=0
  - (c) hold_cnt==MAX_HOLD-1 and (req & ~onehot(o))!=0
- On release, at that edge:
  - grant=0, grant_valid=0, ptr=(o+1) mod 4, state=IDLE.
  - grant_idx keeps o.
  - preempt=1 for exactly one cycle, only when (c) holds and neither (a) nor (b) holds.
- Release forces one bubble cycle, then normal IDLE arbitration from the updated ptr. Handover from release to the next grant is 2 edges.
- Without a release: hold_cnt increments each cycle and saturates at MAX_HOLD-1. The owner keeps the grant indefinitely while no other requester is pending.
- Simultaneous events:
  - done together with req[o] falling gives a single release.
  - done together with timeout counts as a normal release; preempt=0.
  - A new request arriving in the release cycle is arbitrated in the following IDLE cycle.
- Requests from non-owners during GRANT are not stored; they are served because requesters hold req.
- ptr changes only on release. Preempted requesters keep their request and get served again after the others in rotation.
- Reset mid-grant clears everything asynchronously. The next arbitration starts from ptr=0.
- grant is always one-hot or zero. grant_valid == |grant.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 for 3 cycles -> grant=0, grant_valid=0, grant_idx=0, preempt=0; first edge after rst_n=1 -> grant=4'b0001, grant_idx=0.
- Single requester: req=4'b0100 -> next edge grant=4'b0100, grant_idx=2; pulse done -> next edge grant=0, grant_idx stays 2; then req=4'b1001 -> grant_idx=3 (ptr=3).
- Rotation: req=4'b1111 held, done pulsed 1 cycle after each grant -> grant_idx sequence 0,1,2,3,0; one grant_valid=0 bubble between grants.
- Preemption (MAX_HOLD=8): req=4'b0001 held, no done; req[3] rises 2 cycles after the grant -> grant_idx=0 for exactly 8 cycles, preempt=1 for 1 cycle, bubble, then grant_idx=3; after done, grant returns to idx 0.
- No contender: req=4'b0001 held 20 cycles, done=0 -> grant stays 4'b0001 throughout, preempt never 1; dropping req[0] -> next edge grant=0.
- Async reset mid-grant: owner idx 2, drop rst_n between edges -> all outputs 0 before the next edge; release rst_n, req=4'b0110 -> grant_idx=1.

Source files
------------

// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bus between the four requesters and the round-robin arbiter.
//   req         : level request per requester; held until it is served
//   done        : one-cycle release pulse from the current owner
//   grant       : one-hot grant, zero while idle
//   grant_idx   : encoded index of the owner, kept while idle
//   grant_valid : high while any grant bit is set
//   preempt     : one-cycle pulse when a grant is revoked by hold timeout
// The master modport is the requester side. The slave modport is the arbiter side.
interface rr_encoder_arbiter_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, preempt
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, preempt
  );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// Round-robin arbiter that shares one 4-to-2 encoded resource between four
// requesters. It enforces fair rotation and a bounded hold time.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   arb   : request/grant bus (slave side). See rr_encoder_arbiter_if.
// All outputs come from registers. No combinational path runs from req or done
// to an output.
module rr_encoder_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_encoder_arbiter_if.slave  arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state_reg, state_next;
  logic [1:0]        ptr_reg, ptr_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [3:0]        grant_reg, grant_next;
  logic [1:0]        grant_idx_reg, grant_idx_next;
  logic              preempt_reg, preempt_next;

  // Requests rotated so that bit 0 is the requester that ptr points at.
  // The lowest set bit of rot_req is then the round-robin winner.
  logic [3:0] rot_req;
  logic [1:0] win_offset;
  logic [1:0] win;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign rot_req[gi] = arb.req[ptr_reg + 2'(gi)];
    end
  endgenerate

  always_comb begin
    win_offset = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_req[k]) win_offset = 2'(k);
    end
  end

  assign win = ptr_reg + win_offset;

  // Release conditions for the current owner.
  logic rel_done, rel_drop, rel_timeout, release_now;

  assign rel_done    = arb.done;
  assign rel_drop    = !arb.req[grant_idx_reg];
  assign rel_timeout = (hold_cnt_reg == HOLD_LAST) && ((arb.req & ~grant_reg) != 4'd0);
  assign release_now = rel_done || rel_drop || rel_timeout;

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    hold_cnt_next  = hold_cnt_reg;
    grant_next     = grant_reg;
    grant_idx_next = grant_idx_reg;
    preempt_next   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (arb.req != 4'd0) begin
          grant_next     = 4'b0001 << win;
          grant_idx_next = win;
          hold_cnt_next  = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // grant_idx keeps the old owner. The next cycle is a bubble.
          grant_next   = 4'd0;
          ptr_next     = grant_idx_reg + 2'd1;
          state_next   = IDLE;
          // A revocation only counts as a preemption when the owner did not
          // give up the grant on its own in the same cycle.
          preempt_next = rel_timeout && !rel_done && !rel_drop;
        end else if (hold_cnt_reg != HOLD_LAST) begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ptr_reg       <= 2'd0;
      hold_cnt_reg  <= '0;
      grant_reg     <= 4'd0;
      grant_idx_reg <= 2'd0;
      preempt_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      ptr_reg       <= ptr_next;
      hold_cnt_reg  <= hold_cnt_next;
      grant_reg     <= grant_next;
      grant_idx_reg <= grant_idx_next;
      preempt_reg   <= preempt_next;
    end
  end

  assign arb.grant       = grant_reg;
  assign arb.grant_idx   = grant_idx_reg;
  assign arb.grant_valid = |grant_reg;
  assign arb.preempt     = preempt_reg;

endmodule
